// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: direct-mapped instruction cache with a 4-word line refill FSM.
// Optional ICACHE_EARLY_RESTART_EN forwards the critical refill word straight to the fetch port.
module icache_fill_ctrl #(
    parameter int INDEX_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        fetch_en,
    input  logic        inval,
    output logic [15:0] instr,
    output logic        i_hit,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_valid,
    input  logic [15:0] mem_data
);
    localparam int TAG_W = 14 - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t               r_state, w_next;
    logic [LINES-1:0]     r_valid;
    logic [TAG_W-1:0]     r_tag  [LINES];
    logic [15:0]          r_data [LINES][4];
    logic [TAG_W-1:0]     r_miss_tag;
    logic [INDEX_W-1:0]   r_miss_idx;
    logic [1:0]           r_cnt;
    logic                 r_discard;

    logic [TAG_W-1:0]     w_tag;
    logic [INDEX_W-1:0]   w_idx;
    logic [1:0]           w_off;
    logic                 w_match, w_lookup_hit, w_start, w_word_in, w_last, w_fwd;

    assign w_tag        = pc[15:INDEX_W+2];
    assign w_idx        = pc[INDEX_W+1:2];
    assign w_off        = pc[1:0];
    assign w_match      = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_lookup_hit = fetch_en & ~inval & (r_state == IDLE) & w_match;
    assign w_start      = fetch_en & ~inval & (r_state == IDLE) & ~w_match;
    assign w_word_in    = (r_state == FILL) & mem_valid;
    assign w_last       = w_word_in & (r_cnt == 2'd3);
`ifdef ICACHE_EARLY_RESTART_EN
    assign w_fwd        = fetch_en & ~inval & w_word_in & (pc == {r_miss_tag, r_miss_idx, r_cnt});
`else
    assign w_fwd        = 1'b0;
`endif

    always_comb begin
        w_next   = r_state;
        if (r_state == IDLE && w_start)
            w_next = REQ;
        else if (r_state == REQ && mem_ack)
            w_next = FILL;
        else if (w_last)
            w_next = IDLE;
        mem_req  = (r_state == REQ);
        mem_addr = {r_miss_tag, r_miss_idx, 2'b00};
        i_hit    = w_lookup_hit | w_fwd;
        instr    = w_lookup_hit ? r_data[w_idx][w_off] : w_fwd ? mem_data : 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_valid    <= '0;
            r_discard  <= 1'b0;
            r_cnt      <= 2'd0;
            r_miss_tag <= '0;
            r_miss_idx <= '0;
        end else begin
            r_state   <= w_next;
            // An invalidate seen mid-refill must leave the refilled line invalid.
            r_discard <= (r_state != IDLE) & (w_next != IDLE) & (r_discard | inval);
            if (inval)
                r_valid <= '0;
            else if (w_last)
                r_valid[r_miss_idx] <= ~r_discard;
            if (r_state == REQ && mem_ack)
                r_cnt <= 2'd0;
            else if (w_word_in)
                r_cnt <= r_cnt + 2'd1;
            if (w_start) begin
                r_miss_tag <= w_tag;
                r_miss_idx <= w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_word_in)
            r_data[r_miss_idx][r_cnt] <= mem_data;
        if (w_last && !r_discard)
            r_tag[r_miss_idx] <= r_miss_tag;
    end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: scoreboard bench for icache_fill_ctrl; expected hits and
// refill addresses are queued by the stimulus and checked by a negedge monitor.
module tb_icache_fill_ctrl;
    logic        clk, rst_n, fetch_en, inval, mem_ack, mem_valid;
    logic [15:0] pc, mem_data, instr, mem_addr;
    logic        i_hit, mem_req;
    logic [15:0] exp_hit[$];
    logic [15:0] exp_req[$];
    logic [15:0] e;
    int          total = 0;
    int          bad = 0;

    icache_fill_ctrl #(.INDEX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_en(fetch_en), .inval(inval),
        .instr(instr), .i_hit(i_hit), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, a, x, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (i_hit) begin
                if (exp_hit.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_hit: pc=%h instr=%h, expected i_hit=0 (t=%0t)", pc, instr, $time);
                end else begin
                    e = exp_hit.pop_front();
                    chk("hit_instr", instr, e);
                end
            end else
                chk("nohit_instr_zero", instr, 16'h0000);
            if (mem_req && mem_ack) begin
                if (exp_req.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req: mem_addr=%h, expected no refill (t=%0t)", mem_addr, $time);
                end else begin
                    e = exp_req.pop_front();
                    chk("mem_addr", mem_addr, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input logic [15:0] p, input logic [15:0] x);
        pc = p;
        fetch_en = 1;
        exp_hit.push_back(x);
        step();
    endtask

    task automatic refill(input logic [15:0] base, input logic [15:0] d0, input int gap,
                          input int jump_k, input logic [15:0] jump_pc, input int inval_k,
                          input int rst_k);
        int n;
        n = 0;
        exp_req.push_back(base);
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        if (!mem_req) begin
            total++;
            bad++;
            $display("FAIL req_timeout: mem_req=0 after 20 cycles, expected 1 for %h", base);
            void'(exp_req.pop_back());
            return;
        end
        mem_ack = 1;
        step();
        mem_ack = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == rst_k) begin
                rst_n = 0;
                #1;
                chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
                chk("rst_mem_addr", mem_addr, 16'h0000);
                chk("rst_i_hit", {15'd0, i_hit}, 16'd0);
                chk("rst_instr", instr, 16'h0000);
                step();
                rst_n = 1;
                return;
            end
            if (k == jump_k) pc = jump_pc;
            if (k == inval_k) begin
                inval = 1;
                step();
                inval = 0;
            end
            repeat (gap) step();
            mem_valid = 1;
            mem_data  = d0 + 16'(k);
`ifdef ICACHE_EARLY_RESTART_EN
            if (fetch_en && pc == base + 16'(k)) exp_hit.push_back(mem_data);
`endif
            step();
            mem_valid = 0;
        end
    endtask

    initial begin
        clk = 0; rst_n = 0; pc = 16'h0040; fetch_en = 1; inval = 0;
        mem_ack = 0; mem_valid = 0; mem_data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_req", {15'd0, mem_req}, 16'd0);
        chk("reset_mem_addr", mem_addr, 16'h0000);
        chk("reset_i_hit", {15'd0, i_hit}, 16'd0);
        chk("reset_instr", instr, 16'h0000);
        rst_n = 1;
        // cold miss and hits within the line
        refill(16'h0040, 16'hA000, 0, -1, 16'h0, -1, -1);
        hit(16'h0040, 16'hA000);
        hit(16'h0043, 16'hA003);
        hit(16'h0041, 16'hA001);
        // conflict on index 0
        pc = 16'h0060;
        refill(16'h0060, 16'hB000, 0, -1, 16'h0, -1, -1);
        hit(16'h0060, 16'hB000);
        pc = 16'h0040;
        refill(16'h0040, 16'hC000, 0, -1, 16'h0, -1, -1);
        hit(16'h0042, 16'hC002);
        // invalidate on a hit in IDLE: no hit, no refill
        pc = 16'h0040;
        inval = 1;
        step();
        inval = 0;
        chk("inval_idle_no_req", {15'd0, mem_req}, 16'd0);
        // jump mid-fill does not abort the refill
        refill(16'h0040, 16'hD000, 0, 2, 16'h0081, -1, -1);
        hit(16'h0040, 16'hD000);
        pc = 16'h0081;
        refill(16'h0080, 16'hE000, 0, -1, 16'h0, -1, -1);
        hit(16'h0081, 16'hE001);
        // invalidate during fill leaves the line invalid
        pc = 16'h0040;
        refill(16'h0040, 16'hF000, 0, -1, 16'h0, 2, -1);
        refill(16'h0040, 16'hF100, 0, -1, 16'h0, -1, -1);
        hit(16'h0040, 16'hF100);
        // reset mid-fill
        pc = 16'h0060;
        refill(16'h0060, 16'h9000, 0, -1, 16'h0, -1, 2);
        pc = 16'h0040;
        refill(16'h0040, 16'h1000, 0, -1, 16'h0, -1, -1);
        hit(16'h0043, 16'h1003);
        // refill with gaps between data words
        pc = 16'h004A;
        refill(16'h0048, 16'h2000, 2, -1, 16'h0, -1, -1);
        hit(16'h004A, 16'h2002);
        fetch_en = 0;
        step();
        chk("hit_queue_empty", 16'(exp_hit.size()), 16'd0);
        chk("req_queue_empty", 16'(exp_req.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/icache_fill_ctrl.md
# icache_fill_ctrl

Direct-mapped instruction cache and refill controller. It is the supplier side of the IF-stage `i_hit`/instruction interface. Each cycle it answers a fetch at `pc` with a combinational hit/instruction pair. On a miss it runs a line refill from instruction memory, holding `i_hit` low so the IF-stage mux inserts NOPs until the line is resident.

## Interface
Parameters:
- INDEX_W, 3, line index bits; the cache holds 2^INDEX_W lines of 4 × 16-bit words.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc  in  16  fetch word address.
- fetch_en  in  1  fetch request valid this cycle.
- inval  in  1  invalidate all lines (single-cycle pulse).
- instr  out  16  fetched instruction; 16'h0000 whenever i_hit=0.
- i_hit  out  1  instr is valid for pc this cycle.
- mem_req  out  1  line read request; held until accepted.
- mem_addr  out  16  line base word address, {tag,index,2'b00}.
- mem_ack  in  1  memory accepted request (mem_req&mem_ack = handshake).
- mem_valid  in  1  one refill word present on mem_data.
- mem_data  in  16  refill word, delivered in order offset 0,1,2,3.

## Operation
- Address split: offset=pc[1:0], index=pc[INDEX_W+1:2], tag=pc[15:INDEX_W+2].
- Storage: valid bit, tag, and 4 data words per line; combinational (asynchronous) read.
- i_hit = fetch_en & ~inval & state==IDLE & valid[index] & tag match. When i_hit=0, instr = 16'h0000.
- State machine:
  - IDLE: on fetch_en & miss & ~inval, latch {tag,index} into a miss register and go to REQ.
  - REQ: mem_req=1, mem_addr={miss tag,miss index,2'b00}. On mem_ack go to FILL and clear the word counter.
  - FILL: each mem_valid writes mem_data into word[counter] of the miss line and increments the 2-bit counter. On the 4th word, write valid=1 and the tag (unless the discard flag is set), then go to IDLE.
- The miss register is the only address source during REQ/FILL. A pc change mid-refill (jump) does not abort the refill; the new pc is looked up after returning to IDLE.
- inval clears every valid bit in one cycle.
  - In IDLE with a coincident miss: inval wins and no refill starts.
  - In REQ/FILL: sets a discard flag. The refill still completes the handshake and writes data, but leaves valid=0. The flag clears on entering IDLE.
- mem_valid outside FILL is ignored. mem_ack outside REQ is ignored.
- Gaps between mem_valid pulses are legal and unbounded.

## Timing
- Hit: 0-cycle latency; instr/i_hit are combinational from pc in the same cycle.
- Miss: i_hit=0 in the detect cycle, then REQ. The first hit is the cycle after the 4th mem_valid (IDLE re-entered), provided pc is unchanged.
- Minimum miss penalty: 1 (detect) + 1 (ack) + 4 (data) = 6 cycles with back-to-back ack/valid.
- Reset values (async, on rst_n low): state IDLE, all valid=0, discard=0, counter=0, mem_req=0, mem_addr=16'h0000, i_hit=0, instr=16'h0000. Reset mid-refill abandons the refill; the memory side is reset by the same rst_n.

## Configuration
- ICACHE_EARLY_RESTART_EN defined: during FILL, if fetch_en and pc equals {miss tag,miss index,counter} while mem_valid=1, drive i_hit=1 and instr=mem_data in that cycle (forwarding). Inval in that cycle suppresses it.
- Not defined: i_hit is never asserted outside IDLE.

## Test plan
- Cold miss: reset, fetch_en=1, pc=0x0040 → mem_req=1, mem_addr=0x0040. Ack, then 4 valids 0xA000..0xA003 → next cycle i_hit=1, instr=0xA000. Step pc to 0x0043 → i_hit=1, instr=0xA003.
- Conflict: after the fill above, pc=0x0060 (same index 0) → miss, mem_addr=0x0060, refill 0xB000..0xB003. Then pc=0x0040 → miss again.
- Jump mid-fill: miss at 0x0040, switch pc to 0x0081 during FILL → fill completes, 0x0040 line valid, then miss with mem_addr=0x0080.
- Inval during FILL of 0x0040 after word 1 → remaining words accepted, return to IDLE; pc=0x0040 misses again. Inval in IDLE on a hit → i_hit=0 that cycle.
- Reset mid-FILL after 2 words → mem_req=0, state IDLE, all valid=0; pc=0x0040 starts a fresh refill.
- With ICACHE_EARLY_RESTART_EN: miss at pc=0x0042 with mem_valid gaps → i_hit=1, instr=mem_data in exactly the cycle word 2 arrives. Without the macro → i_hit=0 until IDLE.
